simon_round_controller: RTL and testbench
=========================================

// Module: simon_round_controller
// PURPOSE
// - Game sequencer for the Simon Says datapath: builds the colour pattern, plays it on the LEDs,
//   collects and checks player buttons, and drives the score counter (clear / increment).
// - Sits between the debounced button front end, the LED driver and ScoreCounter; single clock domain.
// PARAMETERS
// - MAX_LEN    16      max pattern length (rounds); pattern RAM depth; must be power of 2, >=2
// - TICK_DIV   25000000 clk cycles per playback half-step (LED on or LED off)
// - TIMEOUT_TK 10      playback ticks allowed between player presses (TIMEOUT_EN only)
// - LFSR_SEED  16'hACE1 reset value of 16-bit colour LFSR; must be nonzero
// PORTS
// - clk         in  1  system clock, rising edge
// - reset       in  1  asynchronous, active-low reset (0 = reset)
// - start       in  1  1-cycle pulse; starts a new game from IDLE, WIN or LOSE
// - btn_valid   in  1  1-cycle pulse: one debounced player press
// - btn_code    in  2  colour of press, valid with btn_valid
// - led_on      out 1  LED lit during playback
// - led_code    out 2  colour shown while led_on=1
// - score_clr   out 1  1-cycle pulse to ScoreCounter: clear score
// - score_inc   out 1  1-cycle pulse to ScoreCounter: +1 (one per completed round)
// - round_len   out clog2(MAX_LEN)+1  current pattern length
// - busy        out 1  1 in every state except IDLE/WIN/LOSE
// - game_over   out 1  1 in LOSE; win flag = (state==WIN) exported as game_won
// - game_won    out 1  1 in WIN (MAX_LEN rounds completed)
// BEHAVIOUR
// - Reset (reset=0): state IDLE; all outputs 0; round_len=0; LFSR=LFSR_SEED; tick counter 0.
// - Tick: free counter 0..TICK_DIV-1, tick=1 one cycle at wrap; restarted to 0 on every state entry.
// - LFSR: x^16+x^14+x^13+x^11+1, advances every clk (free-running entropy); colour = lfsr[1:0].
// - FSM (registered outputs, Moore except pulses):
//   IDLE/WIN/LOSE --start--> CLEAR: score_clr=1 one cycle, round_len<=0 -> ADD.
//   ADD: pat[round_len]<=lfsr[1:0]; round_len<=round_len+1; idx<=0 -> SHOW_ON (1 cycle).
//   SHOW_ON: led_on=1, led_code=pat[idx]; on tick -> SHOW_OFF.
//   SHOW_OFF: led_on=0; on tick: idx==round_len-1 ? (idx<=0, WAIT_IN) : (idx++, SHOW_ON).
//   WAIT_IN: on btn_valid: btn_code!=pat[idx] -> LOSE;
//            match & idx<round_len-1 -> idx++, stay; match & idx==round_len-1 -> SCORE.
//   SCORE: score_inc=1 one cycle; round_len==MAX_LEN -> WIN, else -> ADD.
// - btn_valid outside WAIT_IN is ignored (no effect, no error).
// - start while busy is ignored; start and btn_valid in the same cycle in WAIT_IN: btn_valid wins.
// - Exactly one score_inc per completed round; score never incremented on a failed round.
// - round_len saturates at MAX_LEN; pattern index never wraps (idx < round_len <= MAX_LEN).
// - Reset asserted mid-game: immediate return to IDLE, outputs 0, no score pulse emitted;
//   ScoreCounter is cleared only by the next game's score_clr.
// - Latency: start -> score_clr 1 cycle; final correct btn_valid -> score_inc 1 cycle later.
// CONFIGURATION
// - INPUT_TIMEOUT_EN defined: WAIT_IN counts ticks since entry / last accepted press;
//   reaching TIMEOUT_TK ticks -> LOSE (same as wrong press). Counter reset on every btn_valid.
// - INPUT_TIMEOUT_EN undefined: WAIT_IN waits indefinitely; no timeout counter synthesized;
//   TIMEOUT_TK unused.
// TESTING (TICK_DIV=4, MAX_LEN=4, LFSR seeded; bench reads pat[] via led_code during playback)
// - Reset: hold reset=0 3 cycles mid-SHOW_ON -> all outputs 0, round_len=0, busy=0 next cycle.
// - start pulse -> score_clr=1 exactly 1 cycle later, round_len=1, led_on high 4 cycles then low 4.
// - Replay shown colours correctly for rounds 1..4 -> 4 score_inc pulses total, game_won=1, busy=0.
// - Round 2, second press wrong colour -> game_over=1, no score_inc for round 2 (score stays 1).
// - btn_valid during SHOW_ON/SHOW_OFF and start while busy -> no state change, pattern unaffected.
// - INPUT_TIMEOUT_EN, TIMEOUT_TK=3: no press for 12 cycles in WAIT_IN -> game_over=1;
//   press every 8 cycles -> no timeout.

Source files
------------

// File: rtl/simon_round_controller.sv
// Simon Says game sequencer: builds the LFSR colour pattern, plays it back, checks presses, drives score pulses.
// Optional build macro INPUT_TIMEOUT_EN adds a playback-tick timeout while waiting for player input.
module simon_round_controller #(
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned TIMEOUT_TK = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      btn_valid,
    input  logic [1:0]                btn_code,
    output logic                      led_on,
    output logic [1:0]                led_code,
    output logic                      score_clr,
    output logic                      score_inc,
    output logic [$clog2(MAX_LEN):0]  round_len,
    output logic                      busy,
    output logic                      game_over,
    output logic                      game_won,
    output logic [3:0]                dbg_state
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CLEAR    = 4'd1;
    localparam logic [3:0] S_ADD      = 4'd2;
    localparam logic [3:0] S_SHOW_ON  = 4'd3;
    localparam logic [3:0] S_SHOW_OFF = 4'd4;
    localparam logic [3:0] S_WAIT_IN  = 4'd5;
    localparam logic [3:0] S_SCORE    = 4'd6;
    localparam logic [3:0] S_WIN      = 4'd7;
    localparam logic [3:0] S_LOSE     = 4'd8;

    if (MAX_LEN < 2 || (MAX_LEN & (MAX_LEN - 1)) != 0 || TICK_DIV < 1 ||
        TIMEOUT_TK < 1 || LFSR_SEED == 16'h0000) begin : g_param_err
        $error("simon_round_controller: illegal parameter set");
    end

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [IW-1:0] r_idx;
    logic [LW-1:0] r_round_len;
    logic [1:0]    r_pat [MAX_LEN];
    logic [15:0]   r_lfsr;
    logic [TW-1:0] r_tick_cnt;
    logic          r_led_on;
    logic          r_score_clr;
    logic          r_score_inc;
    logic          r_busy;
    logic          r_game_over;
    logic          r_game_won;
    logic          w_tick;
    logic          w_last;
    logic          w_match;
    logic          w_timeout;
    logic          w_lfsr_fb;

    assign w_tick    = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_last    = ({1'b0, r_idx} == (r_round_len - LW'(1)));
    assign w_match   = (btn_code == r_pat[r_idx]);
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

`ifdef INPUT_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_TK + 1);
    logic [TOW-1:0] r_to_cnt;

    // Ticks since WAIT_IN entry or the last press; any press restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT_IN || btn_valid) begin
            r_to_cnt <= '0;
        end else if (w_tick) begin
            r_to_cnt <= r_to_cnt + TOW'(1);
        end
    end

    assign w_timeout = w_tick && (r_to_cnt == TOW'(TIMEOUT_TK - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: if (start) w_next = S_CLEAR;
            S_CLEAR:    w_next = S_ADD;
            S_ADD:      w_next = S_SHOW_ON;
            S_SHOW_ON:  if (w_tick) w_next = S_SHOW_OFF;
            S_SHOW_OFF: if (w_tick) w_next = w_last ? S_WAIT_IN : S_SHOW_ON;
            S_WAIT_IN: begin
                // A press in the same cycle as a timeout takes priority.
                if (btn_valid) begin
                    if (!w_match)    w_next = S_LOSE;
                    else if (w_last) w_next = S_SCORE;
                end else if (w_timeout) begin
                    w_next = S_LOSE;
                end
            end
            S_SCORE:    w_next = (r_round_len == LW'(MAX_LEN)) ? S_WIN : S_ADD;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_round_len <= '0;
            r_lfsr      <= LFSR_SEED;
            r_tick_cnt  <= '0;
            r_led_on    <= 1'b0;
            r_score_clr <= 1'b0;
            r_score_inc <= 1'b0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            r_game_won  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};

            if (w_next != r_state || w_tick) r_tick_cnt <= '0;
            else                             r_tick_cnt <= r_tick_cnt + TW'(1);

            case (r_state)
                S_CLEAR: r_round_len <= '0;
                S_ADD: begin
                    r_idx <= '0;
                    if (r_round_len < LW'(MAX_LEN)) r_round_len <= r_round_len + LW'(1);
                end
                S_SHOW_OFF: if (w_tick) r_idx <= w_last ? '0 : r_idx + IW'(1);
                S_WAIT_IN:  if (btn_valid && w_match && !w_last) r_idx <= r_idx + IW'(1);
                default: ;
            endcase

            r_led_on    <= (w_next == S_SHOW_ON);
            r_score_clr <= (w_next == S_CLEAR);
            r_score_inc <= (w_next == S_SCORE);
            r_busy      <= !(w_next == S_IDLE || w_next == S_WIN || w_next == S_LOSE);
            r_game_over <= (w_next == S_LOSE);
            r_game_won  <= (w_next == S_WIN);
        end
    end

    // Pattern storage carries no reset; only entries below round_len are ever read.
    always_ff @(posedge clk) begin
        if (r_state == S_ADD && r_round_len < LW'(MAX_LEN)) begin
            r_pat[r_round_len[IW-1:0]] <= r_lfsr[1:0];
        end
    end

    assign led_on    = r_led_on;
    assign led_code  = r_led_on ? r_pat[r_idx] : 2'b00;
    assign score_clr = r_score_clr;
    assign score_inc = r_score_inc;
    assign round_len = r_round_len;
    assign busy      = r_busy;
    assign game_over = r_game_over;
    assign game_won  = r_game_won;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_simon_round_controller.sv
// Directed bench for simon_round_controller with TICK_DIV=4, MAX_LEN=4, TIMEOUT_TK=3.
module tb_simon_round_controller;

    localparam int MAX_LEN    = 4;
    localparam int TICK_DIV   = 4;
    localparam int TIMEOUT_TK = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_code;
    logic       led_on;
    logic [1:0] led_code;
    logic       score_clr;
    logic       score_inc;
    logic [2:0] round_len;
    logic       busy;
    logic       game_over;
    logic       game_won;
    logic [3:0] dbg_state;

    simon_round_controller #(
        .MAX_LEN    (MAX_LEN),
        .TICK_DIV   (TICK_DIV),
        .TIMEOUT_TK (TIMEOUT_TK),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn_valid (btn_valid),
        .btn_code  (btn_code),
        .led_on    (led_on),
        .led_code  (led_code),
        .score_clr (score_clr),
        .score_inc (score_inc),
        .round_len (round_len),
        .busy      (busy),
        .game_over (game_over),
        .game_won  (game_won),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int model_score = 0;
    int inc_total   = 0;
    logic [1:0] exp_q[$];

    // score counter model fed by the pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (score_clr) model_score = 0;
        else if (score_inc) begin
            model_score = model_score + 1;
            inc_total   = inc_total + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] code);
        btn_code  = code;
        btn_valid = 1'b1;
        step();
        btn_valid = 1'b0;
        btn_code  = 2'b00;
    endtask

    task automatic noise();
        btn_code  = ~led_code;
        btn_valid = 1'b1;
        start     = 1'b1;
        step();
        btn_valid = 1'b0;
        start     = 1'b0;
        btn_code  = 2'b00;
        check_eq("noise_no_clr", score_clr, 1'b0);
        check_eq("noise_no_over", game_over, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_clr", score_clr, 1'b1);
        check_eq("start_busy", busy, 1'b1);
        step();
        check_eq("clr_one_cycle", score_clr, 1'b0);
    endtask

    task automatic wait_led_high();
        int n = 0;
        while (led_on !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check_eq("led_rise_seen", led_on, 1'b1);
    endtask

    // Watch one full playback, capture colours and compare with the stored pattern.
    task automatic play_round(input int r, input bit inject);
        logic [1:0] seen[$];
        int hi;
        int lo;
        for (int k = 0; k < r; k++) begin
            wait_led_high();
            if (k == 0) check_eq("round_len", round_len, r);
            seen.push_back(led_code);
            hi = 0;
            while (led_on === 1'b1 && hi < 20) begin
                if (inject && k == 0 && hi == 1) noise();
                else step();
                hi++;
            end
            check_eq("led_high_len", hi, 4);
            if (k < r - 1) begin
                lo = 0;
                while (led_on !== 1'b1 && lo < 20) begin
                    step();
                    lo++;
                end
                check_eq("led_low_len", lo, 4);
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (inject && j == 1) noise();
            else step();
        end
        check_eq("wait_busy", busy, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) check_eq("pattern_kept", seen[i], exp_q[i]);
        exp_q.push_back(seen[r-1]);
    endtask

    task automatic replay(input int r, input int wrong_at);
        logic [1:0] c;
        for (int i = 0; i < r; i++) begin
            c = exp_q[i];
            if (i == wrong_at) begin
                press(c ^ 2'b01);
                check_eq("lose_over", game_over, 1'b1);
                check_eq("lose_busy", busy, 1'b0);
                check_eq("lose_no_inc", score_inc, 1'b0);
                return;
            end
            press(c);
            if (i < r - 1) check_eq("mid_no_inc", score_inc, 1'b0);
            else           check_eq("round_inc", score_inc, 1'b1);
        end
    endtask

    initial begin
        int n;
        int inc_before;
        reset = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_code = 2'b00;
        repeat (3) step();
        check_eq("rst_led", led_on, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_len", round_len, 0);
        check_eq("rst_clr", score_clr, 1'b0);
        reset = 1'b1;
        step();
        press(2'b10);
        check_eq("idle_btn_busy", busy, 1'b0);

        // game 1: full win, with noise injected in round 2
        do_start();
        for (int r = 1; r <= MAX_LEN; r++) begin
            play_round(r, r == 2);
            replay(r, -1);
        end
        step();
        check_eq("win_flag", game_won, 1'b1);
        check_eq("win_busy", busy, 1'b0);
        check_eq("win_not_over", game_over, 1'b0);
        check_eq("win_score", model_score, 4);
        check_eq("win_inc_total", inc_total, 4);

        // game 2: second press of round 2 is wrong
        exp_q.delete();
        do_start();
        check_eq("g2_score_clr", model_score, 0);
        play_round(1, 1'b0);
        replay(1, -1);
        play_round(2, 1'b0);
        replay(2, 1);
        repeat (3) step();
        check_eq("lose_stays", game_over, 1'b1);
        check_eq("lose_score", model_score, 1);
        check_eq("lose_inc_total", inc_total, 5);

        // game 3: input wait behaviour
        exp_q.delete();
        do_start();
        play_round(1, 1'b0);
`ifdef INPUT_TIMEOUT_EN
        repeat (7) step();
        press(exp_q[0]);
        check_eq("to_r1_inc", score_inc, 1'b1);
        play_round(2, 1'b0);
        repeat (7) step();
        press(exp_q[0]);
        check_eq("to_r2_alive", game_over, 1'b0);
        repeat (7) step();
        press(exp_q[1]);
        check_eq("to_r2_inc", score_inc, 1'b1);
        play_round(3, 1'b0);
        n = 0;
        while (game_over !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_eq("timeout_cycles", n, 12);
        check_eq("timeout_over", game_over, 1'b1);
        do_start();
`else
        repeat (40) step();
        check_eq("no_timeout_over", game_over, 1'b0);
        check_eq("no_timeout_busy", busy, 1'b1);
        press(exp_q[0]);
        check_eq("late_press_inc", score_inc, 1'b1);
`endif
        // reset in the middle of a playback pulse
        wait_led_high();
        step();
        inc_before = inc_total;
        reset = 1'b0;
        #1;
        check_eq("async_rst_led", led_on, 1'b0);
        check_eq("async_rst_busy", busy, 1'b0);
        repeat (3) step();
        check_eq("hold_rst_len", round_len, 0);
        reset = 1'b1;
        step();
        check_eq("post_rst_busy", busy, 1'b0);
        check_eq("post_rst_len", round_len, 0);
        check_eq("post_rst_led", led_on, 1'b0);
        check_eq("post_rst_inc", score_inc, 1'b0);
        check_eq("post_rst_over", game_over, 1'b0);
        check_eq("rst_no_pulse", inc_total, inc_before);
        do_start();
        check_eq("restart_len", round_len, 0);
        step();
        check_eq("restart_len1", round_len, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
